seq_run_ctrl: RTL and testbench

//  Run controller for the load/count sequential datapath (6-bit X in, 4-bit S, load, 6-bit Z out).

---
 rtl/seq_run_ctrl_pkg.sv | 16 +
 rtl/seq_run_ctrl_if.sv | 37 +++
 rtl/seq_run_ctrl_step_counter.sv | 37 +++
 rtl/seq_run_ctrl.sv | 159 +++++++++++++++
 tb/tb_seq_run_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/seq_run_ctrl_pkg.sv
// Shared types and default widths for the load/count run controller.
// Imported by the interface, the step counter and the top.
package seq_ctrl_pkg;

  localparam int XW_DEF = 6;
  localparam int SW_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLING,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/seq_run_ctrl_if.sv
// Host + datapath bundle for seq_run_ctrl.
// The controller side uses the slave modport.
interface seq_run_ctrl_if
  import seq_ctrl_pkg::*;
#(
  parameter int XW = XW_DEF,
  parameter int SW = SW_DEF
);
  logic          start;
  logic          abort;
  logic [SW-1:0] cfg_s;
  logic [XW-1:0] cfg_x0;
  logic [XW-1:0] cfg_steps;
  logic [XW-1:0] target_z;
  logic [XW-1:0] z_in;
  logic [XW-1:0] x_out;
  logic [SW-1:0] s_out;
  logic          load_out;
  logic          busy;
  logic          done;
  logic          match;
  logic [XW-1:0] steps_taken;

  modport master (
    output start, abort, cfg_s, cfg_x0,
    output cfg_steps, target_z, z_in,
    input  x_out, s_out, load_out,
    input  busy, done, match, steps_taken
  );

  modport slave (
    input  start, abort, cfg_s, cfg_x0,
    input  cfg_steps, target_z, z_in,
    output x_out, s_out, load_out,
    output busy, done, match, steps_taken
  );
endinterface

// File: rtl/seq_run_ctrl_step_counter.sv
// Saturating step counter: counts up to limit_i and then holds.
// term_o flags that the budget has been used up.
module seq_step_counter
  import seq_ctrl_pkg::*;
#(
  parameter int W = XW_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] count_o,
  output logic         term_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign term_o  = (cnt_q == limit_i);
  assign count_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && !term_o)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seq_run_ctrl.sv
// Run controller: loads the datapath, then steps X until Z hits
// the target or the step budget is spent.
module seq_run_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int XW     = XW_DEF,
  parameter int SW     = SW_DEF,
  parameter int SETTLE = 1
) (
  input logic           clk,
  input logic           reset,
  seq_run_ctrl_if.slave bus
);

  localparam logic [2:0] SET_LAST =
    (SETTLE > 0) ? 3'(SETTLE - 1) : 3'd0;

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [SW-1:0] s_q, s_d;
  logic          load_q, load_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          match_q, match_d;
  logic [XW-1:0] taken_q, taken_d;
  logic [XW-1:0] tgt_q, tgt_d;
  logic [XW-1:0] lim_q, lim_d;
  logic [2:0]    set_q, set_d;
  logic          cnt_clr, cnt_en, cnt_term;
  logic [XW-1:0] cnt;

  seq_step_counter #(.W(XW)) u_steps (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .limit_i (lim_q),
    .count_o (cnt),
    .term_o  (cnt_term)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    s_d     = s_q;
    load_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    match_d = match_q;
    taken_d = taken_q;
    tgt_d   = tgt_q;
    lim_d   = lim_q;
    set_d   = set_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d = LOAD;
          x_d     = bus.cfg_x0;
          s_d     = bus.cfg_s;
          load_d  = 1'b1;
          busy_d  = 1'b1;
          match_d = 1'b0;
          tgt_d   = bus.target_z;
          lim_d   = bus.cfg_steps;
          set_d   = '0;
          cnt_clr = 1'b1;
        end
      end
      LOAD: begin
        state_d = (SETTLE == 0) ? RUN : SETTLING;
      end
      SETTLING: begin
        if (set_q == SET_LAST)
          state_d = RUN;
        else
          set_d = set_q + 3'd1;
      end
      RUN: begin
        // Target compare takes priority over budget exhaustion
        if (bus.z_in == tgt_q) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          match_d = 1'b1;
          taken_d = cnt;
        end else if (cnt_term) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          match_d = 1'b0;
          taken_d = cnt;
        end else begin
          x_d    = x_q + 1'b1;
          cnt_en = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort drops the run silently; steps_taken keeps the last result
    if (bus.abort && (state_q inside {LOAD, SETTLING, RUN})) begin
      state_d = IDLE;
      x_d     = '0;
      s_d     = '0;
      load_d  = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      match_d = 1'b0;
      set_d   = '0;
      cnt_clr = 1'b1;
      cnt_en  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      s_q     <= '0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
      taken_q <= '0;
      tgt_q   <= '0;
      lim_q   <= '0;
      set_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      s_q     <= s_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      match_q <= match_d;
      taken_q <= taken_d;
      tgt_q   <= tgt_d;
      lim_q   <= lim_d;
      set_q   <= set_d;
    end
  end

  assign bus.x_out       = x_q;
  assign bus.s_out       = s_q;
  assign bus.load_out    = load_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.match       = match_q;
  assign bus.steps_taken = taken_q;

endmodule

// File: tb/tb_seq_run_ctrl.sv
// Scoreboard bench for seq_run_ctrl with a Z = X datapath model.
// Stimulus pushes expected load/done records; a monitor pops them.
module tb_seq_run_ctrl;

  typedef struct {
    logic       m;
    logic [5:0] tk;
    logic [5:0] xf;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;

  exp_t       dq[$];
  logic [9:0] lq[$];
  exp_t       e;
  logic [9:0] le;

  seq_run_ctrl_if bus ();

  seq_run_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.z_in = bus.x_out;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.load_out) begin
        if (lq.size() == 0) begin
          chk("unexpected_load", 32'(bus.load_out), 32'd0);
        end else begin
          le = lq.pop_front();
          chk("load_x", 32'(bus.x_out), 32'(le[9:4]));
          chk("load_s", 32'(bus.s_out), 32'(le[3:0]));
          chk("load_busy", 32'(bus.busy), 32'd1);
        end
      end
      if (bus.done) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", 32'(bus.done), 32'd0);
        end else begin
          e = dq.pop_front();
          chk("done_match", 32'(bus.match), 32'(e.m));
          chk("done_steps", 32'(bus.steps_taken), 32'(e.tk));
          chk("done_x", 32'(bus.x_out), 32'(e.xf));
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("done_busy", 32'(bus.busy), 32'd0);
        end
      end
    end
  end

  task automatic start_run(input logic [5:0] x0, input logic [3:0] s,
                           input logic [5:0] st, input logic [5:0] tg,
                           input bit expd, input logic m,
                           input logic [5:0] tk, input logic [5:0] xf);
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.cfg_x0    = x0;
    bus.cfg_s     = s;
    bus.cfg_steps = st;
    bus.target_z  = tg;
    lq.push_back({x0, s});
    if (expd)
      dq.push_back('{m: m, tk: tk, xf: xf, cyc: cyc + 4 + int'(tk)});
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.cfg_x0    = 6'h2A;
    bus.cfg_s     = 4'hF;
    bus.cfg_steps = 6'd1;
    bus.target_z  = 6'h2B;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((dq.size() != 0 || lq.size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (dq.size() != 0 || lq.size() != 0) begin
      chk("timeout", 32'(dq.size() + lq.size()), 32'd0);
      dq.delete();
      lq.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_x"}, 32'(bus.x_out), 32'd0);
    chk({tag, "_s"}, 32'(bus.s_out), 32'd0);
    chk({tag, "_load"}, 32'(bus.load_out), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_match"}, 32'(bus.match), 32'd0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.cfg_s     = '0;
    bus.cfg_x0    = '0;
    bus.cfg_steps = '0;
    bus.target_z  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    chk("reset_steps", 32'(bus.steps_taken), 32'd0);
    reset = 1'b0;

    // match after 4 steps; a second start while busy must be ignored
    start_run(6'd5, 4'd3, 6'd20, 6'd9, 1, 1'b1, 6'd4, 6'd9);
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.cfg_x0    = 6'd30;
    bus.cfg_steps = 6'd0;
    bus.target_z  = 6'd30;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy_during_run", 32'(bus.busy), 32'd1);
    wait_idle();

    // budget exhausted
    start_run(6'd0, 4'd1, 6'd6, 6'd40, 1, 1'b0, 6'd6, 6'd6);
    wait_idle();

    // X wraps 3F -> 00
    start_run(6'h3E, 4'd7, 6'd3, 6'd1, 1, 1'b1, 6'd3, 6'd1);
    wait_idle();

    // zero budget, compare only
    start_run(6'd5, 4'd2, 6'd0, 6'd9, 1, 1'b0, 6'd0, 6'd5);
    wait_idle();

    // zero budget, immediate hit
    start_run(6'd12, 4'd2, 6'd0, 6'd12, 1, 1'b1, 6'd0, 6'd12);
    wait_idle();

    // target reached on the final budget step
    start_run(6'd10, 4'd4, 6'd5, 6'd15, 1, 1'b1, 6'd5, 6'd15);
    wait_idle();

    // abort two cycles into RUN
    start_run(6'd0, 4'd9, 6'd30, 6'd50, 0, 1'b0, 6'd0, 6'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("pre_abort_x", 32'(bus.x_out), 32'd2);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    chk_zero("abort");
    chk("abort_steps", 32'(bus.steps_taken), 32'd5);
    repeat (6) @(posedge clk);
    start_run(6'd1, 4'd2, 6'd10, 6'd3, 1, 1'b1, 6'd2, 6'd3);
    wait_idle();

    // abort and start together in IDLE
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.abort  = 1'b1;
    bus.cfg_x0 = 6'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("abort_start_busy", 32'(bus.busy), 32'd0);
    repeat (4) @(posedge clk);

    // asynchronous reset in the middle of RUN
    start_run(6'd0, 4'd5, 6'd30, 6'd50, 0, 1'b0, 6'd0, 6'd0);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk_zero("midreset");
    chk("midreset_steps", 32'(bus.steps_taken), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("post_reset_busy", 32'(bus.busy), 32'd0);

    start_run(6'd20, 4'd6, 6'd8, 6'd22, 1, 1'b1, 6'd2, 6'd22);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
